// File: rtl/hazard_if.sv
// Pipeline-control bus between the 5-stage core datapath and hazard_ctrl.
// The datapath side drives the stage tags and the memory status; hazard_ctrl returns the stalls, flushes, forwarding selects and status.
interface hazard_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       rs1_addrD;
  logic [4:0]       rs2_addrD;
  logic [4:0]       rs1_addrE;
  logic [4:0]       rs2_addrE;
  logic [4:0]       rdE;
  logic             MemReadE;
  logic             PCSrcE;
  logic [4:0]       rdM;
  logic             RegWriteM;
  logic             MemReqM;
  logic             MemReadyM;
  logic [4:0]       rdW;
  logic             RegWriteW;
  logic             StallF;
  logic             StallD;
  logic             StallE;
  logic             StallM;
  logic             FlushD;
  logic             FlushE;
  logic             FlushW;
  logic [1:0]       ForwardAE;
  logic [1:0]       ForwardBE;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic             dbg_state;

  modport master (
    output rs1_addrD, rs2_addrD, rs1_addrE, rs2_addrE, rdE, MemReadE, PCSrcE,
    output rdM, RegWriteM, MemReqM, MemReadyM, rdW, RegWriteW,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
    input  ForwardAE, ForwardBE, mem_timeout, stall_cnt, flush_cnt, dbg_state
  );

  modport slave (
    input  rs1_addrD, rs2_addrD, rs1_addrE, rs2_addrE, rdE, MemReadE, PCSrcE,
    input  rdM, RegWriteM, MemReqM, MemReadyM, rdW, RegWriteW,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
    output ForwardAE, ForwardBE, mem_timeout, stall_cnt, flush_cnt, dbg_state
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard and forwarding control for the 5-stage core: combinational stall/flush/forward
// decisions, a RUN/MEM_WAIT tracker for slow data memory, and saturating perf counters.
module hazard_ctrl #(
  parameter int CNT_W    = 32,
  parameter int MAX_WAIT = 16
) (
  input logic     clk,
  input logic     rst,
  hazard_if.slave bus
);
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] MAX_W = WW'(MAX_WAIT);
  localparam logic [WW-1:0] ONE_W = WW'(1);

  typedef enum logic {ST_RUN = 1'b0, ST_MEM_WAIT = 1'b1} state_t;

  state_t           r_state;
  logic [WW-1:0]    r_wait_cnt;
  logic             r_mem_timeout;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic             w_mem_stall;
  logic             w_lw_stall;
  logic             w_branch;
  logic             w_stall_f;
  logic             w_stall_d;
  logic             w_stall_e;
  logic             w_stall_m;
  logic             w_flush_d;
  logic             w_flush_e;
  logic             w_flush_w;
  logic [1:0]       w_fwd_a;
  logic [1:0]       w_fwd_b;
  logic [WW-1:0]    w_wait_inc;

  // Every hazard term is gated by rst so the pipeline sees a quiet control bus during reset.
  assign w_mem_stall = ~rst & bus.MemReqM & ~bus.MemReadyM;
  assign w_lw_stall  = ~rst & bus.MemReadE & (bus.rdE != 5'd0) &
                       ((bus.rdE == bus.rs1_addrD) | (bus.rdE == bus.rs2_addrD));
  assign w_branch    = ~rst & bus.PCSrcE;

  always_comb begin
    w_fwd_a = 2'b00;
    w_fwd_b = 2'b00;
    if (!rst) begin
      if (bus.RegWriteM && (bus.rdM != 5'd0) && (bus.rdM == bus.rs1_addrE)) begin
        w_fwd_a = 2'b10;
      end else if (bus.RegWriteW && (bus.rdW != 5'd0) && (bus.rdW == bus.rs1_addrE)) begin
        w_fwd_a = 2'b01;
      end
      if (bus.RegWriteM && (bus.rdM != 5'd0) && (bus.rdM == bus.rs2_addrE)) begin
        w_fwd_b = 2'b10;
      end else if (bus.RegWriteW && (bus.rdW != 5'd0) && (bus.rdW == bus.rs2_addrE)) begin
        w_fwd_b = 2'b01;
      end
    end
  end

  // A memory freeze holds EX too, so a pending PCSrcE simply reappears in the release cycle.
  always_comb begin
    w_stall_f = 1'b0;
    w_stall_d = 1'b0;
    w_stall_e = 1'b0;
    w_stall_m = 1'b0;
    w_flush_d = 1'b0;
    w_flush_e = 1'b0;
    w_flush_w = 1'b0;
    if (w_mem_stall) begin
      w_stall_f = 1'b1;
      w_stall_d = 1'b1;
      w_stall_e = 1'b1;
      w_stall_m = 1'b1;
      w_flush_w = 1'b1;
    end else if (w_branch) begin
      w_flush_d = 1'b1;
      w_flush_e = 1'b1;
    end else if (w_lw_stall) begin
      w_stall_f = 1'b1;
      w_stall_d = 1'b1;
      w_flush_e = 1'b1;
    end
  end

  assign w_wait_inc = (r_wait_cnt == MAX_W) ? r_wait_cnt : r_wait_cnt + ONE_W;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_RUN;
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
      r_stall_cnt   <= '0;
      r_flush_cnt   <= '0;
    end else begin
      if (w_stall_f && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (w_flush_e && (r_flush_cnt != {CNT_W{1'b1}})) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
      case (r_state)
        ST_RUN: begin
          if (w_mem_stall) begin
            r_state    <= ST_MEM_WAIT;
            r_wait_cnt <= ONE_W;
            if (ONE_W == MAX_W) r_mem_timeout <= 1'b1;
          end
        end
        ST_MEM_WAIT: begin
          // Leaves on ready or on a withdrawn request; the timeout never forces an exit.
          if (!w_mem_stall) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
          end else begin
            r_wait_cnt <= w_wait_inc;
            if (w_wait_inc == MAX_W) r_mem_timeout <= 1'b1;
          end
        end
        default: begin
          r_state    <= ST_RUN;
          r_wait_cnt <= '0;
        end
      endcase
    end
  end

  assign bus.StallF      = w_stall_f;
  assign bus.StallD      = w_stall_d;
  assign bus.StallE      = w_stall_e;
  assign bus.StallM      = w_stall_m;
  assign bus.FlushD      = w_flush_d;
  assign bus.FlushE      = w_flush_e;
  assign bus.FlushW      = w_flush_w;
  assign bus.ForwardAE   = w_fwd_a;
  assign bus.ForwardBE   = w_fwd_b;
  assign bus.mem_timeout = r_mem_timeout;
  assign bus.stall_cnt   = r_stall_cnt;
  assign bus.flush_cnt   = r_flush_cnt;
  assign bus.dbg_state   = r_state;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: forwarding, load-use, branch priority, memory waits,
// deferred flush with timeout, reset mid-wait and counter saturation.
module tb_hazard_ctrl;
  localparam int CNT_W    = 4;
  localparam int MAX_WAIT = 4;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  hazard_if #(.CNT_W(CNT_W)) bus ();

  hazard_ctrl #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
  logic [6:0] ctl;
  assign ctl = {bus.StallF, bus.StallD, bus.StallE, bus.StallM, bus.FlushD, bus.FlushE, bus.FlushW};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.rs1_addrD = '0; bus.rs2_addrD = '0; bus.rs1_addrE = '0; bus.rs2_addrE = '0;
    bus.rdE = '0; bus.MemReadE = 1'b0; bus.PCSrcE = 1'b0;
    bus.rdM = '0; bus.RegWriteM = 1'b0; bus.MemReqM = 1'b0; bus.MemReadyM = 1'b0;
    bus.rdW = '0; bus.RegWriteW = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    bus.MemReqM = 1'b1; bus.PCSrcE = 1'b1;
    bus.RegWriteM = 1'b1; bus.rdM = 5'd5; bus.rs1_addrE = 5'd5;
    #1;
    n_checks++;
    if (ctl !== 7'b0000000) begin
      n_errors++; $display("FAIL reset_ctl: got %b expected %b", ctl, 7'b0000000);
    end
    n_checks++;
    if (bus.ForwardAE !== 2'b00) begin
      n_errors++; $display("FAIL reset_fwd: got %b expected 00", bus.ForwardAE);
    end
    tick();
    n_checks++;
    if ({bus.dbg_state, bus.mem_timeout, bus.stall_cnt, bus.flush_cnt} !== 10'd0) begin
      n_errors++;
      $display("FAIL reset_state: state=%b timeout=%b stall_cnt=%0d flush_cnt=%0d expected all 0",
               bus.dbg_state, bus.mem_timeout, bus.stall_cnt, bus.flush_cnt);
    end
    rst = 1'b0;
    clear_inputs();
    #1;
  endtask

  task automatic test_forwarding();
    do_reset();
    bus.rdM = 5'd5; bus.RegWriteM = 1'b1; bus.rdW = 5'd5; bus.RegWriteW = 1'b1; bus.rs1_addrE = 5'd5;
    #1;
    n_checks++;
    if (bus.ForwardAE !== 2'b10) begin
      n_errors++; $display("FAIL fwd_mem_prio: got %b expected 10", bus.ForwardAE);
    end
    bus.RegWriteM = 1'b0;
    #1;
    n_checks++;
    if (bus.ForwardAE !== 2'b01) begin
      n_errors++; $display("FAIL fwd_wb: got %b expected 01", bus.ForwardAE);
    end
    bus.RegWriteM = 1'b1; bus.rdM = 5'd0; bus.rdW = 5'd0; bus.rs1_addrE = 5'd0;
    #1;
    n_checks++;
    if (bus.ForwardAE !== 2'b00) begin
      n_errors++; $display("FAIL fwd_x0: got %b expected 00", bus.ForwardAE);
    end
    bus.rs1_addrE = 5'd5; bus.rs2_addrE = 5'd6;
    bus.rdM = 5'd3; bus.RegWriteM = 1'b1; bus.rdW = 5'd6; bus.RegWriteW = 1'b1;
    #1;
    n_checks++;
    if ({bus.ForwardAE, bus.ForwardBE} !== 4'b0001) begin
      n_errors++; $display("FAIL fwd_b_wb: got A=%b B=%b expected A=00 B=01", bus.ForwardAE, bus.ForwardBE);
    end
    bus.rdM = 5'd6;
    #1;
    n_checks++;
    if (bus.ForwardBE !== 2'b10) begin
      n_errors++; $display("FAIL fwd_b_mem: got %b expected 10", bus.ForwardBE);
    end
    clear_inputs();
  endtask

  task automatic test_load_use();
    do_reset();
    bus.MemReadE = 1'b1; bus.rdE = 5'd7; bus.rs2_addrD = 5'd7;
    #1;
    n_checks++;
    if (ctl !== 7'b1100010) begin
      n_errors++; $display("FAIL load_use_ctl: got %b expected %b", ctl, 7'b1100010);
    end
    tick();
    clear_inputs();
    #1;
    n_checks++;
    if (ctl !== 7'b0000000) begin
      n_errors++; $display("FAIL load_use_release: got %b expected %b", ctl, 7'b0000000);
    end
    n_checks++;
    if ({bus.stall_cnt, bus.flush_cnt} !== {4'd1, 4'd1}) begin
      n_errors++; $display("FAIL load_use_cnt: got stall=%0d flush=%0d expected 1 1", bus.stall_cnt, bus.flush_cnt);
    end
    bus.MemReadE = 1'b1; bus.rdE = 5'd0; bus.rs1_addrD = 5'd0;
    #1;
    n_checks++;
    if (ctl !== 7'b0000000) begin
      n_errors++; $display("FAIL load_use_x0: got %b expected %b", ctl, 7'b0000000);
    end
    clear_inputs();
  endtask

  task automatic test_branch_beats_lw();
    do_reset();
    bus.MemReadE = 1'b1; bus.rdE = 5'd7; bus.rs1_addrD = 5'd7; bus.PCSrcE = 1'b1;
    #1;
    n_checks++;
    if (ctl !== 7'b0000110) begin
      n_errors++; $display("FAIL branch_ctl: got %b expected %b", ctl, 7'b0000110);
    end
    tick();
    clear_inputs();
    n_checks++;
    if ({bus.stall_cnt, bus.flush_cnt} !== {4'd0, 4'd1}) begin
      n_errors++; $display("FAIL branch_cnt: got stall=%0d flush=%0d expected 0 1", bus.stall_cnt, bus.flush_cnt);
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    bus.MemReqM = 1'b1; bus.MemReadyM = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (ctl !== 7'b1111001) begin
        n_errors++; $display("FAIL mem_wait_ctl[%0d]: got %b expected %b", i, ctl, 7'b1111001);
      end
      tick();
      n_checks++;
      if (bus.dbg_state !== 1'b1) begin
        n_errors++; $display("FAIL mem_wait_state[%0d]: got %b expected 1", i, bus.dbg_state);
      end
    end
    bus.MemReadyM = 1'b1;
    #1;
    n_checks++;
    if (ctl !== 7'b0000000) begin
      n_errors++; $display("FAIL mem_release_ctl: got %b expected %b", ctl, 7'b0000000);
    end
    tick();
    n_checks++;
    if ({bus.dbg_state, bus.mem_timeout, bus.stall_cnt, bus.flush_cnt} !== {1'b0, 1'b0, 4'd3, 4'd0}) begin
      n_errors++;
      $display("FAIL mem_release_state: state=%b timeout=%b stall=%0d flush=%0d expected 0 0 3 0",
               bus.dbg_state, bus.mem_timeout, bus.stall_cnt, bus.flush_cnt);
    end
    bus.MemReadyM = 1'b0;
    tick();
    bus.MemReqM = 1'b0;
    tick();
    n_checks++;
    if (bus.dbg_state !== 1'b0) begin
      n_errors++; $display("FAIL mem_req_drop: got state %b expected 0", bus.dbg_state);
    end
    clear_inputs();
  endtask

  task automatic test_deferred_flush_timeout();
    do_reset();
    bus.PCSrcE = 1'b1; bus.MemReqM = 1'b1; bus.MemReadyM = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++;
      if ({bus.FlushD, bus.FlushE} !== 2'b00) begin
        n_errors++; $display("FAIL defer_flush[%0d]: got %b expected 00", i, {bus.FlushD, bus.FlushE});
      end
      tick();
      n_checks++;
      if (bus.mem_timeout !== (i >= 3)) begin
        n_errors++; $display("FAIL timeout[%0d]: got %b expected %b", i, bus.mem_timeout, (i >= 3));
      end
    end
    bus.MemReadyM = 1'b1;
    #1;
    n_checks++;
    if (ctl !== 7'b0000110) begin
      n_errors++; $display("FAIL defer_release_ctl: got %b expected %b", ctl, 7'b0000110);
    end
    tick();
    clear_inputs();
    tick();
    tick();
    n_checks++;
    if ({bus.dbg_state, bus.mem_timeout, bus.stall_cnt, bus.flush_cnt} !== {1'b0, 1'b1, 4'd5, 4'd1}) begin
      n_errors++;
      $display("FAIL defer_after: state=%b timeout=%b stall=%0d flush=%0d expected 0 1 5 1",
               bus.dbg_state, bus.mem_timeout, bus.stall_cnt, bus.flush_cnt);
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    bus.MemReqM = 1'b1; bus.MemReadyM = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    n_checks++;
    if (ctl !== 7'b0000000) begin
      n_errors++; $display("FAIL rst_wait_ctl: got %b expected %b", ctl, 7'b0000000);
    end
    tick();
    n_checks++;
    if ({bus.dbg_state, bus.mem_timeout, bus.stall_cnt, bus.flush_cnt} !== 10'd0) begin
      n_errors++;
      $display("FAIL rst_wait_state: state=%b timeout=%b stall=%0d flush=%0d expected all 0",
               bus.dbg_state, bus.mem_timeout, bus.stall_cnt, bus.flush_cnt);
    end
    rst = 1'b0;
    clear_inputs();
    #1;
  endtask

  task automatic test_saturation();
    do_reset();
    bus.MemReadE = 1'b1; bus.rdE = 5'd3; bus.rs1_addrD = 5'd3;
    for (int i = 0; i < 20; i++) tick();
    n_checks++;
    if ({bus.stall_cnt, bus.flush_cnt} !== {4'd15, 4'd15}) begin
      n_errors++; $display("FAIL saturate: got stall=%0d flush=%0d expected 15 15", bus.stall_cnt, bus.flush_cnt);
    end
    clear_inputs();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch_beats_lw();
    test_mem_wait();
    test_deferred_flush_timeout();
    test_reset_mid_wait();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
